// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the SPI initiator that drives the AES decrypt core.
package aes_spi_pkg;

    localparam int unsigned FRAME_BITS = 258;
    localparam int unsigned BIT_CNT_W  = 9;
    localparam int unsigned KEY_W      = 256;
    localparam int unsigned BLK_W      = 128;

    localparam logic [1:0] KS_128 = 2'b00;
    localparam logic [1:0] KS_192 = 2'b01;
    localparam logic [1:0] KS_256 = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_WAIT,
        ST_FINISH
    } state_e;

    typedef enum logic [1:0] {
        PH_KEY,
        PH_MSG,
        PH_READ
    } phase_e;

    typedef struct packed {
        logic [1:0]       ks;
        logic [KEY_W-1:0] key;
        logic [BLK_W-1:0] data;
    } txn_t;

    // The reserved size code goes out on the wire as AES-256.
    function automatic logic [1:0] wire_ks(input logic [1:0] ks);
        return (ks == 2'b11) ? KS_256 : ks;
    endfunction

    function automatic logic [FRAME_BITS-1:0] frame_bits(input phase_e ph, input txn_t t);
        case (ph)
            PH_KEY:  return {wire_ks(t.ks), t.key};
            PH_MSG:  return {130'b0, t.data};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Divider producing a 50% duty sclk with one-cycle edge strobes; idles low when disabled.
module spi_clk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             sclk_q, sclk_d;
    logic             wrap_c;

    always_comb begin
        wrap_c    = en && (div_q == DIV_W'(CLK_DIV - 1));
        rise_tick = wrap_c && !sclk_q;
        fall_tick = wrap_c && sclk_q;
        div_d     = '0;
        sclk_d    = 1'b0;
        if (en) begin
            div_d  = wrap_c ? '0 : div_q + 1'b1;
            sclk_d = wrap_c ? ~sclk_q : sclk_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/aes_spi_master.sv
// SPI initiator: key frame, ciphertext frame, free-running gap for the core, then plaintext read-back.
module aes_spi_master
    import aes_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned GAP_SCLKS = 64,
    parameter int unsigned CS_IDLE   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       key_size,
    input  logic [KEY_W-1:0] key,
    input  logic [BLK_W-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [BLK_W-1:0] data_out,
    output logic             cs,
    output logic             sclk,
    output logic             sdo,
    input  logic             sdi
);

    localparam int unsigned CNT_MAX0 = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > GAP_SCLKS) ? CNT_MAX0 : GAP_SCLKS;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    state_e                state_q, state_d;
    phase_e                phase_q, phase_d;
    logic [BIT_CNT_W-1:0]  bit_q, bit_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    txn_t                  txn_q, txn_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [BLK_W-1:0]      rx_q, rx_d;
    logic [BLK_W-1:0]      dout_q, dout_d;
    logic                  cs_q, cs_d;
    logic                  sdo_q, sdo_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  clk_en_c;
    logic                  rise_tick, fall_tick;

    assign clk_en_c = (state_q == ST_SHIFT) || (state_q == ST_WAIT);

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (clk_en_c),
        .sclk      (sclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        txn_d   = txn_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        cs_d    = cs_q;
        sdo_d   = sdo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    txn_d   = '{ks: key_size, key: key, data: data_in};
                    phase_d = PH_KEY;
                    tx_d    = frame_bits(PH_KEY, txn_d);
                    sdo_d   = tx_d[FRAME_BITS-1];
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_SHIFT: begin
                if (rise_tick && (phase_q == PH_READ) && (bit_q < BIT_CNT_W'(BLK_W))) begin
                    rx_d = {rx_q[BLK_W-2:0], sdi};
                end
                if (fall_tick) begin
                    if (bit_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
                        bit_d   = '0;
                        cnt_d   = '0;
                        cs_d    = 1'b1;
                        sdo_d   = 1'b0;
                        state_d = ST_HOLD;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sdo_d = tx_q[FRAME_BITS-2];
                        tx_d  = {tx_q[FRAME_BITS-2:0], 1'b0};
                    end
                end
            end

            ST_HOLD: begin
                bit_d = '0;
                if (cnt_q == CNT_W'(CS_IDLE - 1)) begin
                    cnt_d = '0;
                    case (phase_q)
                        PH_KEY: begin
                            phase_d = PH_MSG;
                            tx_d    = frame_bits(PH_MSG, txn_q);
                            sdo_d   = tx_d[FRAME_BITS-1];
                            cs_d    = 1'b0;
                            state_d = ST_SETUP;
                        end
                        PH_MSG:  state_d = ST_WAIT;
                        default: state_d = ST_FINISH;
                    endcase
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // sclk keeps running with cs released so the core can finish decrypting.
            ST_WAIT: begin
                bit_d = '0;
                if (fall_tick) begin
                    if (cnt_q == CNT_W'(GAP_SCLKS - 1)) begin
                        cnt_d   = '0;
                        phase_d = PH_READ;
                        tx_d    = '0;
                        rx_d    = '0;
                        sdo_d   = 1'b0;
                        cs_d    = 1'b0;
                        state_d = ST_SETUP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_FINISH: begin
                dout_d  = rx_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                phase_d = PH_KEY;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= PH_KEY;
            bit_q   <= '0;
            cnt_q   <= '0;
            txn_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            cs_q    <= 1'b1;
            sdo_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            txn_q   <= txn_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            cs_q    <= cs_d;
            sdo_q   <= sdo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = dout_q;
    assign cs       = cs_q;
    assign sdo      = sdo_q;

endmodule
